// File: rtl/id_ex_stage_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | id_ex_stage_pkg: control-word layout shared by decoder and ID/EX stage |
// | Revision: 1.0                                                          |
// +-----------------------------------------------------------------------+
package id_ex_stage_pkg;

  localparam int CTRL_W = 14;

  localparam int CTL_REG_DST    = 13;
  localparam int CTL_ALU_SRC    = 12;
  localparam int CTL_MEM_TO_REG = 11;
  localparam int CTL_REG_WRITE  = 10;
  localparam int CTL_MEM_READ   = 9;
  localparam int CTL_MEM_WRITE  = 8;
  localparam int CTL_BRANCH     = 7;
  localparam int CTL_ALU_OP_HI  = 6;
  localparam int CTL_ALU_OP_LO  = 4;
  localparam int CTL_EXT_TYPE   = 3;
  localparam int CTL_BNE        = 2;
  localparam int CTL_DSIZE_HI   = 1;
  localparam int CTL_DSIZE_LO   = 0;

  typedef logic [CTRL_W-1:0] ctrl_t;

  // All-zero control word is the pipeline bubble: no write, no memory access.
  localparam ctrl_t CTRL_NOP = '0;

  function automatic logic uses_rt(input ctrl_t c);
    return c[CTL_REG_DST] | c[CTL_MEM_WRITE] | c[CTL_BRANCH] | c[CTL_BNE];
  endfunction

endpackage
`default_nettype wire

// File: rtl/id_ex_stage_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | id_ex_stage_if: D-stage inputs and E-stage outputs of the ID/EX stage  |
// | Revision: 1.0                                                          |
// +-----------------------------------------------------------------------+
interface id_ex_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
);
  id_ex_stage_pkg::ctrl_t Ctrl_D;
  logic                   Valid_D;
  logic [REG_AW-1:0]      Rs_D;
  logic [REG_AW-1:0]      Rt_D;
  logic [REG_AW-1:0]      Rd_D;
  logic [DATA_W-1:0]      RD1_D;
  logic [DATA_W-1:0]      RD2_D;
  logic [DATA_W-1:0]      Imm_D;
  logic                   Flush_E;
  logic                   Hold;

  id_ex_stage_pkg::ctrl_t Ctrl_E;
  logic                   Valid_E;
  logic [REG_AW-1:0]      Rs_E;
  logic [REG_AW-1:0]      Rt_E;
  logic [REG_AW-1:0]      Write_Reg_E;
  logic [DATA_W-1:0]      RD1_E;
  logic [DATA_W-1:0]      RD2_E;
  logic [DATA_W-1:0]      Imm_E;
  logic                   Stall_F;
  logic                   Stall_D;

  modport master (
    output Ctrl_D, Valid_D, Rs_D, Rt_D, Rd_D, RD1_D, RD2_D, Imm_D, Flush_E, Hold,
    input  Ctrl_E, Valid_E, Rs_E, Rt_E, Write_Reg_E, RD1_E, RD2_E, Imm_E,
           Stall_F, Stall_D
  );

  modport slave (
    input  Ctrl_D, Valid_D, Rs_D, Rt_D, Rd_D, RD1_D, RD2_D, Imm_D, Flush_E, Hold,
    output Ctrl_E, Valid_E, Rs_E, Rt_E, Write_Reg_E, RD1_E, RD2_E, Imm_E,
           Stall_F, Stall_D
  );
endinterface
`default_nettype wire

// File: rtl/id_ex_stage_load_use_detect.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | load_use_detect: flags a D-stage instruction that needs a load in E    |
// | Revision: 1.0                                                          |
// +-----------------------------------------------------------------------+
module load_use_detect
  import id_ex_stage_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  ctrl_t             ctrl_e_i,
  input  logic              valid_e_i,
  input  logic [REG_AW-1:0] rt_e_i,
  input  ctrl_t             ctrl_d_i,
  input  logic              valid_d_i,
  input  logic [REG_AW-1:0] rs_d_i,
  input  logic [REG_AW-1:0] rt_d_i,
  output logic              lu_hazard_o
);
  logic w_uses_rt;
  logic w_unused_ctrl;

  assign w_uses_rt     = uses_rt(ctrl_d_i);
  assign w_unused_ctrl = ^{ctrl_e_i, ctrl_d_i};

  // A load into $0 never produces a value worth waiting for.
  assign lu_hazard_o = valid_e_i & ctrl_e_i[CTL_MEM_READ] & (rt_e_i != '0) & valid_d_i &
                       ((rt_e_i == rs_d_i) | (w_uses_rt & (rt_e_i == rt_d_i)));

endmodule
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | id_ex_stage: ID/EX pipeline register with load-use stall and flush.    |
// | Optional ID_EX_PERF_CNT_EN adds saturating bubble/hold counters.       |
// | Revision: 1.0                                                          |
// +-----------------------------------------------------------------------+
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  id_ex_stage_if.slave bus
`ifdef ID_EX_PERF_CNT_EN
  ,
  output logic [31:0]  Bubble_Cnt,
  output logic [31:0]  Hold_Cnt
`endif
);
  ctrl_t             ctrl_q,  ctrl_d;
  logic              valid_q, valid_d;
  logic [REG_AW-1:0] rs_q,  rs_d;
  logic [REG_AW-1:0] rt_q,  rt_d;
  logic [REG_AW-1:0] wr_q,  wr_d;
  logic [DATA_W-1:0] rd1_q, rd1_d;
  logic [DATA_W-1:0] rd2_q, rd2_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic              w_lu_hazard;
  logic              w_bubble;

  load_use_detect #(.REG_AW(REG_AW)) u_load_use_detect (
    .ctrl_e_i    (ctrl_q),
    .valid_e_i   (valid_q),
    .rt_e_i      (rt_q),
    .ctrl_d_i    (bus.Ctrl_D),
    .valid_d_i   (bus.Valid_D),
    .rs_d_i      (bus.Rs_D),
    .rt_d_i      (bus.Rt_D),
    .lu_hazard_o (w_lu_hazard)
  );

  assign w_bubble    = bus.Flush_E | w_lu_hazard;
  assign bus.Stall_F = bus.Hold | w_lu_hazard;
  assign bus.Stall_D = bus.Hold | w_lu_hazard;

  // Hold outranks bubble insertion, so a stalled load stays in E until Hold drops.
  always_comb begin
    ctrl_d  = ctrl_q;
    valid_d = valid_q;
    rs_d    = rs_q;
    rt_d    = rt_q;
    wr_d    = wr_q;
    rd1_d   = rd1_q;
    rd2_d   = rd2_q;
    imm_d   = imm_q;
    if (!bus.Hold) begin
      if (w_bubble) begin
        ctrl_d  = CTRL_NOP;
        valid_d = 1'b0;
        rs_d    = '0;
        rt_d    = '0;
        wr_d    = '0;
        rd1_d   = '0;
        rd2_d   = '0;
        imm_d   = '0;
      end else begin
        ctrl_d  = bus.Valid_D ? bus.Ctrl_D : CTRL_NOP;
        valid_d = bus.Valid_D;
        rs_d    = bus.Rs_D;
        rt_d    = bus.Rt_D;
        wr_d    = bus.Ctrl_D[CTL_REG_DST] ? bus.Rd_D : bus.Rt_D;
        rd1_d   = bus.RD1_D;
        rd2_d   = bus.RD2_D;
        imm_d   = bus.Imm_D;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q  <= CTRL_NOP;
      valid_q <= 1'b0;
      rs_q    <= '0;
      rt_q    <= '0;
      wr_q    <= '0;
      rd1_q   <= '0;
      rd2_q   <= '0;
      imm_q   <= '0;
    end else begin
      ctrl_q  <= ctrl_d;
      valid_q <= valid_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      wr_q    <= wr_d;
      rd1_q   <= rd1_d;
      rd2_q   <= rd2_d;
      imm_q   <= imm_d;
    end
  end

  assign bus.Ctrl_E      = ctrl_q;
  assign bus.Valid_E     = valid_q;
  assign bus.Rs_E        = rs_q;
  assign bus.Rt_E        = rt_q;
  assign bus.Write_Reg_E = wr_q;
  assign bus.RD1_E       = rd1_q;
  assign bus.RD2_E       = rd2_q;
  assign bus.Imm_E       = imm_q;

`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] bubble_cnt_q;
  logic [31:0] hold_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt_q <= '0;
      hold_cnt_q   <= '0;
    end else begin
      if (!bus.Hold && w_bubble && (bubble_cnt_q != '1)) begin
        bubble_cnt_q <= bubble_cnt_q + 32'd1;
      end
      if (bus.Hold && (hold_cnt_q != '1)) begin
        hold_cnt_q <= hold_cnt_q + 32'd1;
      end
    end
  end

  assign Bubble_Cnt = bubble_cnt_q;
  assign Hold_Cnt   = hold_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_id_ex_stage: directed vectors with a scoreboard queue and monitor   |
// | Revision: 1.0                                                          |
// +-----------------------------------------------------------------------+
module tb_id_ex_stage;
  import id_ex_stage_pkg::*;

  // {RegDst,ALUSrc,MemToReg,RegWrite,MemRead,MemWrite,Branch,ALUOp,Ext,BNE,Size}
  localparam ctrl_t LW   = 14'b0_1_1_1_1_0_0_000_1_0_00;
  localparam ctrl_t ADD  = 14'b1_0_0_1_0_0_0_010_0_0_00;
  localparam ctrl_t ADDI = 14'b0_1_0_1_0_0_0_000_1_0_00;
  localparam ctrl_t SW   = 14'b0_1_0_0_0_1_0_000_1_0_00;
  localparam ctrl_t BEQ  = 14'b0_0_0_0_0_0_1_001_1_0_00;
  localparam ctrl_t NOP  = 14'b0;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  typedef struct {
    logic        st;
    ctrl_t       c;
    logic        v;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  wr;
    logic [7:0]  tag;
  } exp_t;

  exp_t q[$];

  id_ex_stage_if #(.DATA_W(32), .REG_AW(5)) bus ();

  id_ex_stage #(.DATA_W(32), .REG_AW(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] d1(input logic [7:0] t);
    return (t == 8'd0) ? 32'd0 : (32'h1100_0000 | {24'd0, t});
  endfunction
  function automatic logic [31:0] d2(input logic [7:0] t);
    return (t == 8'd0) ? 32'd0 : (32'h2200_0000 | {24'd0, t});
  endfunction
  function automatic logic [31:0] di(input logic [7:0] t);
    return (t == 8'd0) ? 32'd0 : (32'h0000_F000 | {24'd0, t});
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_e_zero(input string tag);
    chk({tag, " Ctrl_E"},      32'(bus.Ctrl_E),      32'd0);
    chk({tag, " Valid_E"},     32'(bus.Valid_E),     32'd0);
    chk({tag, " Rs_E"},        32'(bus.Rs_E),        32'd0);
    chk({tag, " Rt_E"},        32'(bus.Rt_E),        32'd0);
    chk({tag, " Write_Reg_E"}, 32'(bus.Write_Reg_E), 32'd0);
    chk({tag, " RD1_E"},       bus.RD1_E,            32'd0);
    chk({tag, " RD2_E"},       bus.RD2_E,            32'd0);
    chk({tag, " Imm_E"},       bus.Imm_E,            32'd0);
  endtask

  task automatic set_d(input ctrl_t c, input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic fl, input logic hd, input logic [7:0] tag);
    bus.Ctrl_D  = c;
    bus.Valid_D = v;
    bus.Rs_D    = rs;
    bus.Rt_D    = rt;
    bus.Rd_D    = rd;
    bus.RD1_D   = d1(tag);
    bus.RD2_D   = d2(tag);
    bus.Imm_D   = di(tag);
    bus.Flush_E = fl;
    bus.Hold    = hd;
  endtask

  // One cycle: drive D inputs, queue the stall expected now and the E contents after the edge.
  task automatic cyc(input ctrl_t c, input logic v, input logic [4:0] rs, input logic [4:0] rt,
                     input logic [4:0] rd, input logic fl, input logic hd, input logic [7:0] tag,
                     input logic x_st, input ctrl_t x_c, input logic x_v, input logic [4:0] x_rs,
                     input logic [4:0] x_rt, input logic [4:0] x_wr, input logic [7:0] x_tag);
    exp_t e;
    @(negedge clk);
    set_d(c, v, rs, rt, rd, fl, hd, tag);
    e.st = x_st; e.c = x_c; e.v = x_v; e.rs = x_rs; e.rt = x_rt; e.wr = x_wr; e.tag = x_tag;
    q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() != 0) begin
        chk("Stall_F", 32'(bus.Stall_F), 32'(q[0].st));
        chk("Stall_D", 32'(bus.Stall_D), 32'(q[0].st));
        @(posedge clk);
        #1;
        e = q.pop_front();
        chk("Ctrl_E",      32'(bus.Ctrl_E),      32'(e.c));
        chk("Valid_E",     32'(bus.Valid_E),     32'(e.v));
        chk("Rs_E",        32'(bus.Rs_E),        32'(e.rs));
        chk("Rt_E",        32'(bus.Rt_E),        32'(e.rt));
        chk("Write_Reg_E", 32'(bus.Write_Reg_E), 32'(e.wr));
        chk("RD1_E",       bus.RD1_E,            d1(e.tag));
        chk("RD2_E",       bus.RD2_E,            d2(e.tag));
        chk("Imm_E",       bus.Imm_E,            di(e.tag));
      end
    end
  end

  initial begin : watchdog
    #20000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    set_d(LW, 1'b1, 5'd3, 5'd4, 5'd5, 1'b0, 1'b0, 8'hAA);
    repeat (2) @(posedge clk);
    #1;
    chk_e_zero("reset");

    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("release Ctrl_E", 32'(bus.Ctrl_E), 32'(14'b01111000001000));
    chk("release Valid_E", 32'(bus.Valid_E), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_e_zero("async reset");

    @(negedge clk);
    set_d(NOP, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 8'd0);
    rst_n = 1'b1;

    //   D: ctrl  v  rs  rt  rd fl hd tag   | stall  E: ctrl  v  rs  rt  wr  tag
    cyc(LW,   1, 2,  9,  0, 0, 0, 1,   0, LW,   1, 2, 9,  9,  1);
    cyc(ADD,  1, 3,  4, 12, 0, 0, 2,   0, ADD,  1, 3, 4, 12,  2);
    cyc(LW,   1, 0,  8,  0, 0, 0, 3,   0, LW,   1, 0, 8,  8,  3);
    cyc(ADD,  1, 8,  5, 10, 0, 0, 4,   1, NOP,  0, 0, 0,  0,  0);
    cyc(ADD,  1, 8,  5, 10, 0, 0, 4,   0, ADD,  1, 8, 5, 10,  4);
    cyc(LW,   1, 1,  8,  0, 0, 0, 5,   0, LW,   1, 1, 8,  8,  5);
    cyc(ADDI, 1, 3,  8,  0, 0, 0, 6,   0, ADDI, 1, 3, 8,  8,  6);
    cyc(LW,   1, 1,  7,  0, 0, 0, 7,   0, LW,   1, 1, 7,  7,  7);
    cyc(SW,   1, 2,  7,  0, 0, 0, 8,   1, NOP,  0, 0, 0,  0,  0);
    cyc(SW,   1, 2,  7,  0, 0, 0, 8,   0, SW,   1, 2, 7,  7,  8);
    cyc(LW,   1, 0,  0,  0, 0, 0, 9,   0, LW,   1, 0, 0,  0,  9);
    cyc(ADD,  1, 0,  0, 13, 0, 0, 10,  0, ADD,  1, 0, 0, 13, 10);
    cyc(ADD,  1, 1,  2,  3, 1, 0, 11,  0, NOP,  0, 0, 0,  0,  0);
    cyc(LW,   1, 1,  6,  0, 0, 0, 12,  0, LW,   1, 1, 6,  6, 12);
    cyc(ADD,  1, 6,  1,  4, 0, 1, 13,  1, LW,   1, 1, 6,  6, 12);
    cyc(ADD,  1, 6,  1,  4, 0, 1, 13,  1, LW,   1, 1, 6,  6, 12);
    cyc(ADD,  1, 6,  1,  4, 0, 1, 13,  1, LW,   1, 1, 6,  6, 12);
    cyc(ADD,  1, 6,  1,  4, 0, 0, 13,  1, NOP,  0, 0, 0,  0,  0);
    cyc(ADD,  1, 6,  1,  4, 0, 0, 13,  0, ADD,  1, 6, 1,  4, 13);
    cyc(ADD,  0, 1,  2,  3, 0, 0, 14,  0, NOP,  0, 1, 2,  3, 14);
    cyc(LW,   1, 1,  5,  0, 0, 0, 15,  0, LW,   1, 1, 5,  5, 15);
    cyc(ADD,  1, 5,  2,  3, 1, 0, 16,  1, NOP,  0, 0, 0,  0,  0);
    cyc(BEQ,  1, 4,  5,  0, 0, 0, 17,  0, BEQ,  1, 4, 5,  5, 17);
    cyc(ADD,  1, 1,  2,  3, 0, 1, 18,  1, BEQ,  1, 4, 5,  5, 17);
    cyc(LW,   1, 1,  9,  0, 0, 0, 19,  0, LW,   1, 1, 9,  9, 19);

    for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
    #2;
    chk("scoreboard drained", 32'(q.size()), 32'd0);

    // Reset in the middle of a load-use stall: E clears and the stall falls at once.
    @(negedge clk);
    set_d(ADD, 1'b1, 5'd9, 5'd2, 5'd3, 1'b0, 1'b0, 8'd20);
    #2;
    chk("pre-reset Stall_D", 32'(bus.Stall_D), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid-stall reset Stall_F", 32'(bus.Stall_F), 32'd0);
    chk("mid-stall reset Stall_D", 32'(bus.Stall_D), 32'd0);
    chk_e_zero("mid-stall reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode-to-execute pipeline boundary of the 5-stage MIPS core.
- Registers the 14-bit control word from the opcode decoder, together with D-stage operands, register numbers and immediate, into E-stage outputs.
- Contains the load-use hazard detector that stalls F/D and injects a bubble into E.
- Also honours an external flush (taken branch) and a global hold (memory wait).

Parameters:
- DATA_W, 32, datapath width
- REG_AW, 5, register-file address width
- CTRL_W, 14, control word width (fixed by decoder encoding)

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- Ctrl_D  in  CTRL_W  decoded control, bit13..0 = {Reg_Dst, ALU_Src, Mem_To_Reg, Reg_Write, Mem_Read, Mem_Write, Branch, ALU_OP[2:0], ext_type, Branch_Not_Equal, data_size[1:0]}
- Valid_D  in  1  D holds a real instruction
- Rs_D, Rt_D, Rd_D  in  REG_AW each  instruction register fields
- RD1_D, RD2_D  in  DATA_W each  register-file read data
- Imm_D  in  DATA_W  extended immediate
- Flush_E  in  1  turn next E contents into a bubble (taken branch)
- Hold  in  1  global freeze
- Ctrl_E  out  CTRL_W  registered control word
- Valid_E  out  1  E holds a real instruction
- Rs_E, Rt_E  out  REG_AW each  for forwarding unit
- Write_Reg_E  out  REG_AW  destination register: Rd if Reg_Dst else Rt, resolved at capture
- RD1_E, RD2_E, Imm_E  out  DATA_W each
- Stall_F, Stall_D  out  1 each  combinational, freeze PC and IF/ID

Behaviour:
- Reset (rst_n=0, async): every registered output 0, Valid_E=0. The all-zero Ctrl_E is the bubble: no write, no memory access.
- Latency: one clock, D inputs to E outputs.
- uses_rt_D = Reg_Dst | Mem_Write | Branch | Branch_Not_Equal, taken from Ctrl_D.
- lu_hazard (combinational) = Valid_E & Mem_Read_E & (Rt_E != 0) & Valid_D & ((Rt_E == Rs_D) | (uses_rt_D & Rt_E == Rt_D)).
- Stall_F = Stall_D = Hold | lu_hazard.
- Per-edge update, priority order:
  1. Hold=1: all E registers keep their values.
  2. Else Flush_E=1 or lu_hazard=1: bubble (Ctrl_E=0, Valid_E=0, Write_Reg_E=0). Data fields are don't-care and are zeroed.
  3. Else: capture all D inputs. Valid_E=Valid_D. If Valid_D=0, Ctrl_E=0.
- Simultaneous Flush_E and lu_hazard: single bubble. The stall still asserts that cycle.
- A load-use stall lasts exactly one cycle: after the bubble, Mem_Read_E=0, so lu_hazard drops.
- Hold during lu_hazard: E keeps the load, stall persists, and the bubble is inserted on the first cycle Hold=0.
- Load into $0 (Rt_E=0): no stall.
- Reset asserted mid-stall: outputs clear immediately and stall outputs fall, since Valid_E=0.

Optional Feature:
- Macro: ID_EX_PERF_CNT_EN.
- Defined: adds outputs Bubble_Cnt and Hold_Cnt (32 bits each). Bubble_Cnt increments on each bubble-insert edge; Hold_Cnt increments on each edge with Hold=1. Both saturate at all-ones and reset to 0.
- Undefined: these ports and their logic do not exist.

Decomposition:
- Shared package holds:
  - CTRL_W
  - bit-index constants for each control field, matching the order above
  - CTRL_NOP = 0
  - The decoder and this block both use these constants.
- One sub-module: load_use_detect. It is combinational, takes Ctrl_E/Valid_E/Rt_E and Ctrl_D/Valid_D/Rs_D/Rt_D, and outputs lu_hazard.

Test Plan:
- Reset: drive nonzero D inputs, rst_n=0 between edges -> all E outputs 0 immediately. After release with LW in D, Ctrl_E=14'b01111000001000 one edge later.
- Load-use: LW $t0 in E (Rt_E=8, Mem_Read=1); ADD with Rs_D=8 in D -> Stall_F=Stall_D=1 one cycle, next Ctrl_E=0, Valid_E=0; ADD enters E the following edge.
- No false stall: LW into $0, or ADDI in D with Rt_D=8 (uses_rt=0) -> Stall_D=0, normal capture.
- Flush: Flush_E=1 with BEQ-shadow instruction in D -> Ctrl_E=0, Valid_E=0, no stall.
- Hold: Hold=1 for 3 cycles with lu_hazard present -> E unchanged, Stall_D=1 throughout; bubble on first edge after Hold drops.
- Write_Reg_E: R-format Rd=12, Rt=9 -> Write_Reg_E=12. LW Rt=9 -> Write_Reg_E=9.
